// File: rtl/gelu_seq_ctrl.sv
// Sequencer that streams a source buffer through the fp16 GELU datapath one element
// at a time and writes each result back to a destination buffer.
module gelu_seq_ctrl #(
    parameter int ADDR_W = 10,
    parameter int LAT    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   count,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [15:0]       rd_data,
    output logic              gelu_valid,
    output logic [15:0]       gelu_in,
    input  logic [15:0]       gelu_result,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [3:0] WAIT_LOAD = 4'(LAT - 1);

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_src_ptr;
    logic [ADDR_W-1:0] r_dst_ptr;
    logic [ADDR_W:0]   r_len;
    logic [ADDR_W:0]   r_count;
    logic [ADDR_W:0]   w_count_inc;
    logic [3:0]        r_wait_cnt;
    logic [15:0]       r_gelu_in;
    logic              w_abort;

    assign w_count_inc = r_count + (ADDR_W + 1)'(1);
    assign w_abort     = abort && (r_state == S_FETCH || r_state == S_ISSUE ||
                                   r_state == S_WAIT  || r_state == S_WRITE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = (len == '0) ? S_DONE : S_FETCH;
            S_FETCH: w_next = S_ISSUE;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT:  if (r_wait_cnt == 4'd0) w_next = S_WRITE;
            S_WRITE: w_next = (w_count_inc == r_len) ? S_DONE : S_FETCH;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        // Abort only redirects the next state; the current cycle's strobe still fires.
        if (w_abort) w_next = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_src_ptr  <= '0;
            r_dst_ptr  <= '0;
            r_len      <= '0;
            r_count    <= '0;
            r_wait_cnt <= '0;
            r_gelu_in  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_src_ptr <= src_base;
                        r_dst_ptr <= dst_base;
                        r_len     <= len;
                        r_count   <= '0;
                    end
                end
                S_ISSUE: begin
                    r_gelu_in  <= rd_data;
                    r_wait_cnt <= WAIT_LOAD;
                end
                S_WAIT: begin
                    if (r_wait_cnt != 4'd0) r_wait_cnt <= r_wait_cnt - 4'd1;
                end
                S_WRITE: begin
                    r_src_ptr <= r_src_ptr + ADDR_W'(1);
                    r_dst_ptr <= r_dst_ptr + ADDR_W'(1);
                    r_count   <= w_count_inc;
                end
                default: ;
            endcase
        end
    end

    // The GELU input register samples only on gelu_valid, so gelu_in is held between issues.
    assign busy       = (r_state != S_IDLE);
    assign done       = (r_state == S_DONE);
    assign count      = r_count;
    assign rd_en      = (r_state == S_FETCH);
    assign rd_addr    = r_src_ptr;
    assign gelu_valid = (r_state == S_ISSUE);
    assign gelu_in    = (r_state == S_ISSUE) ? rd_data : r_gelu_in;
    assign wr_en      = (r_state == S_WRITE);
    assign wr_addr    = r_dst_ptr;
    assign wr_data    = (r_state == S_WRITE) ? gelu_result : 16'h0000;

endmodule

// File: tb/tb_gelu_seq_ctrl.sv
// Directed bench for gelu_seq_ctrl: source memory, latency-LAT GELU model and
// per-cycle capture of every strobe, checked against hand-computed values.
module tb_gelu_seq_ctrl;

    localparam int ADDR_W = 10;
    localparam int LAT    = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              abort;
    logic [ADDR_W-1:0] src_base;
    logic [ADDR_W-1:0] dst_base;
    logic [ADDR_W:0]   len;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   count;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [15:0]       rd_data;
    logic              gelu_valid;
    logic [15:0]       gelu_in;
    logic [15:0]       gelu_result;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [15:0]       wr_data;

    gelu_seq_ctrl #(.ADDR_W(ADDR_W), .LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .src_base(src_base), .dst_base(dst_base), .len(len),
        .busy(busy), .done(done), .count(count),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .gelu_valid(gelu_valid), .gelu_in(gelu_in), .gelu_result(gelu_result),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    always #5 clk = ~clk;

    // Reference GELU values for a few fp16 points; other inputs get a distinct stand-in map.
    function automatic logic [15:0] gelu_ref(input logic [15:0] x);
        case (x)
            16'h3C00: return 16'h3ABB;
            16'hBC00: return 16'hB114;
            16'h0000: return 16'h0000;
            default:  return x ^ 16'h5A5A;
        endcase
    endfunction

    logic [15:0] src_mem [1024];
    always @(posedge clk) if (rd_en) rd_data <= src_mem[rd_addr];

    logic [15:0] g_in_r;
    logic [15:0] g_pipe [LAT];
    always @(posedge clk) begin
        if (gelu_valid) g_in_r <= gelu_in;
        g_pipe[0] <= gelu_ref(g_in_r);
        for (int i = 1; i < LAT; i++) g_pipe[i] <= g_pipe[i-1];
    end
    assign gelu_result = g_pipe[LAT-1];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    int              n_wr, n_rd, n_iss, n_done, done_cyc, end_cyc, gv_long, gin_bad;
    logic [ADDR_W-1:0] wr_a [16];
    logic [15:0]       wr_d [16];
    int                wr_c [16];
    logic [ADDR_W-1:0] rd_a [16];

    task automatic run_job(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] d,
                           input logic [ADDR_W:0] n, input int abort_at, input int restart_at);
        logic        holding;
        logic        prev_gv;
        logic [15:0] held;
        n_wr = 0; n_rd = 0; n_iss = 0; n_done = 0; done_cyc = -1; end_cyc = -1;
        gv_long = 0; gin_bad = 0; holding = 1'b0; prev_gv = 1'b0; held = '0;
        src_base = s; dst_base = d; len = n; start = 1'b1;
        @(posedge clk); #1;
        for (int k = 1; k <= 400; k++) begin
            abort = (k == abort_at);
            if (k == restart_at) begin
                start = 1'b1; src_base = 10'h155; dst_base = 10'h2AA; len = 11'd7;
            end else begin
                start = 1'b0;
            end
            if (rd_en) begin
                if (n_rd < 16) rd_a[n_rd] = rd_addr;
                n_rd++;
            end
            if (gelu_valid) begin
                n_iss++;
                if (prev_gv) gv_long++;
                held = gelu_in;
                holding = 1'b1;
            end else if (holding) begin
                if (gelu_in !== held) gin_bad++;
                if (rd_en) holding = 1'b0;
            end
            prev_gv = gelu_valid;
            if (wr_en) begin
                if (n_wr < 16) begin
                    wr_a[n_wr] = wr_addr; wr_d[n_wr] = wr_data; wr_c[n_wr] = k;
                end
                n_wr++;
            end
            if (done) begin
                if (done_cyc < 0) done_cyc = k;
                n_done++;
            end
            if (!busy) begin
                end_cyc = k;
                break;
            end
            @(posedge clk); #1;
        end
        abort = 1'b0; start = 1'b0;
    endtask

    initial begin
        logic found;
        for (int i = 0; i < 1024; i++) src_mem[i] = 16'h1000 + 16'(i);
        src_mem[10'h100] = 16'h3C00;
        src_mem[10'h101] = 16'hBC00;
        src_mem[10'h102] = 16'h0000;

        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        src_base = '0; dst_base = '0; len = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_strobes", 32'({rd_en, gelu_valid, wr_en}), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_addrs", 32'({rd_addr, wr_addr}), 0);
        chk("rst_data", 32'({wr_data, gelu_in}), 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Empty job, with an abort in the DONE cycle that must be ignored.
        run_job(10'h000, 10'h020, 11'd0, 1, -1);
        chk("len0_done_cyc", done_cyc, 1);
        chk("len0_end_cyc", end_cyc, 2);
        chk("len0_n_done", n_done, 1);
        chk("len0_strobes", n_rd + n_iss + n_wr, 0);
        chk("len0_count", 32'(count), 0);

        // Main job; start re-pulsed with junk inputs while busy.
        run_job(10'h010, 10'h200, 11'd3, -1, 5);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("main_wr_cyc%0d", i), wr_c[i], 7 * (i + 1));
            chk($sformatf("main_wr_addr%0d", i), 32'(wr_a[i]), 32'h200 + i);
            chk($sformatf("main_wr_data%0d", i), 32'(wr_d[i]), 32'(gelu_ref(16'h1010 + 16'(i))));
            chk($sformatf("main_rd_addr%0d", i), 32'(rd_a[i]), 32'h010 + i);
        end
        chk("main_n_wr", n_wr, 3);
        chk("main_done_cyc", done_cyc, 22);
        chk("main_end_cyc", end_cyc, 23);
        chk("main_count", 32'(count), 3);
        chk("main_n_iss", n_iss, 3);
        chk("main_gv_single", gv_long, 0);
        chk("main_gin_stable", gin_bad, 0);

        // Pointer wrap at the top of the address space.
        run_job(10'h3FE, 10'h3FF, 11'd3, -1, -1);
        chk("wrap_rd0", 32'(rd_a[0]), 32'h3FE);
        chk("wrap_rd1", 32'(rd_a[1]), 32'h3FF);
        chk("wrap_rd2", 32'(rd_a[2]), 32'h000);
        chk("wrap_wr0", 32'(wr_a[0]), 32'h3FF);
        chk("wrap_wr1", 32'(wr_a[1]), 32'h000);
        chk("wrap_wr2", 32'(wr_a[2]), 32'h001);
        chk("wrap_data2", 32'(wr_d[2]), 32'(16'h1000 ^ 16'h5A5A));
        chk("wrap_count", 32'(count), 3);

        // Reference GELU points.
        run_job(10'h100, 10'h050, 11'd3, -1, -1);
        chk("val_one", 32'(wr_d[0]), 32'h3ABB);
        chk("val_neg_one", 32'(wr_d[1]), 32'hB114);
        chk("val_zero", 32'(wr_d[2]), 32'h0000);
        chk("val_gin_stable", gin_bad, 0);

        // Abort in WAIT of element 2 (cycles 10..13).
        run_job(10'h010, 10'h200, 11'd5, 11, -1);
        chk("abw_end_cyc", end_cyc, 12);
        chk("abw_n_done", n_done, 0);
        chk("abw_n_wr", n_wr, 1);
        chk("abw_count", 32'(count), 1);

        // Abort in WRITE of element 2 (cycle 14): the write still lands.
        run_job(10'h010, 10'h200, 11'd5, 14, -1);
        chk("abwr_end_cyc", end_cyc, 15);
        chk("abwr_n_done", n_done, 0);
        chk("abwr_n_wr", n_wr, 2);
        chk("abwr_wr_cyc1", wr_c[1], 14);
        chk("abwr_count", 32'(count), 2);

        // Asynchronous reset during the first WRITE.
        src_base = 10'h010; dst_base = 10'h200; len = 11'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (wr_en) begin
                found = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        chk("rstw_reached_write", 32'(found), 1);
        rst_n = 1'b0;
        #1;
        chk("rstw_busy", 32'(busy), 0);
        chk("rstw_strobes", 32'({rd_en, gelu_valid, wr_en, done}), 0);
        chk("rstw_count", 32'(count), 0);
        chk("rstw_addrs", 32'({rd_addr, wr_addr}), 0);
        chk("rstw_data", 32'({wr_data, gelu_in}), 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        run_job(10'h100, 10'h060, 11'd1, -1, -1);
        chk("post_wr_cyc", wr_c[0], 7);
        chk("post_wr_addr", 32'(wr_a[0]), 32'h060);
        chk("post_wr_data", 32'(wr_d[0]), 32'h3ABB);
        chk("post_done_cyc", done_cyc, 8);
        chk("post_count", 32'(count), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
